// File: rtl/sid_multi_writer.sv
// sid_multi_writer
//   Buffers SID register-write frames from the SPI decoder in a FIFO. It
//   replays them onto a shared SID bus with one chip select per chip, at
//   most one write per sid_clk period, and sequences the SID reset pulse
//   after system reset.
//
// Optional feature (macro SID_MIRROR_EN):
//   When defined, a shadow copy of every chip's 32 registers is kept and
//   can be read back through rd_chip/rd_addr -> rd_data (1 clk latency).
//   When undefined, rd_data is tied to 0 and rd_chip/rd_addr are ignored.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   wr_valid/wr_ready     write-frame handshake (ready = FIFO not full)
//   wr_chip/wr_bcast      target chip index, or broadcast to all chips
//   wr_addr/wr_data       SID register address / data
//   ovf_clr               clears the sticky overflow flag
//   sid_clk               SID phase-2 clock (CLK_DIV clk cycles per period)
//   sid_addr/sid_data     shared SID bus
//   sid_cs_n              active-low chip selects, one per chip
//   sid_rw                1 = read/idle, 0 = write
//   sid_rst               active-low SID reset
//   fifo_level            current FIFO occupancy
//   overflow              sticky, set when a frame is dropped
//   busy                  reset sequence running, FIFO non-empty or write active
//   rd_chip/rd_addr       mirror read address
//   rd_data               mirror read data
module sid_multi_writer #(
  parameter int NUM_SID    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 16,
  parameter int RST_CYCLES = 16,
  localparam int CHIP_W    = (NUM_SID > 1) ? $clog2(NUM_SID) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CHIP_W-1:0]  wr_chip,
  input  logic               wr_bcast,
  input  logic [4:0]         wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               ovf_clr,
  output logic               sid_clk,
  output logic [4:0]         sid_addr,
  output logic [7:0]         sid_data,
  output logic [NUM_SID-1:0] sid_cs_n,
  output logic               sid_rw,
  output logic               sid_rst,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic               busy,
  input  logic [CHIP_W-1:0]  rd_chip,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_data
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = 1 + CHIP_W + 5 + 8;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int RCNT_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Phase-clock divider
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sid_clk;
  logic             w_fall;
  logic             w_stb;

  assign w_fall    = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_cnt_nxt = w_fall ? '0 : r_cnt + CNT_W'(1);
  // Bus changes one clk after the cycle where sid_clk fell, giving hold
  // time after the SID latching edge.
  assign w_stb     = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sid_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_sid_clk <= (w_cnt_nxt >= CNT_W'(CLK_DIV / 2));
    end
  end

  // Write FIFO
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_h_bcast;
  logic [CHIP_W-1:0] w_h_chip;
  logic [4:0]        w_h_addr;
  logic [7:0]        w_h_data;
  logic              w_h_valid;
  logic [NUM_SID-1:0] w_h_sel_n;

  assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);
  assign wr_ready = !w_full;
  assign w_push   = wr_valid && !w_full;
  assign w_drop   = wr_valid && w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {wr_bcast, wr_chip, wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign w_h_bcast = w_head[ENT_W-1];
  assign w_h_chip  = w_head[13 +: CHIP_W];
  assign w_h_addr  = w_head[12:8];
  assign w_h_data  = w_head[7:0];
  // Frames aimed at a non-existent chip are consumed without a bus write.
  assign w_h_valid = w_h_bcast || ({1'b0, w_h_chip} < (CHIP_W + 1)'(NUM_SID));

  always_comb begin
    w_h_sel_n = '1;
    for (int i = 0; i < NUM_SID; i++) begin
      w_h_sel_n[i] = !(w_h_bcast || (w_h_chip == CHIP_W'(i)));
    end
  end

  // Bus sequencer
  state_t             r_state;
  state_t             w_state_nxt;
  logic [RCNT_W-1:0]  r_rcnt;
  logic [RCNT_W-1:0]  w_rcnt_nxt;
  logic               r_sid_rst;
  logic               w_rst_nxt;
  logic [NUM_SID-1:0] r_cs_n;
  logic [NUM_SID-1:0] w_cs_nxt;
  logic               r_rw;
  logic               w_rw_nxt;
  logic [4:0]         r_addr;
  logic [4:0]         w_addr_nxt;
  logic [7:0]         r_data;
  logic [7:0]         w_data_nxt;
  logic               w_shadow_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_rcnt    <= '0;
      r_sid_rst <= 1'b0;
      r_cs_n    <= '1;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_sid_rst <= w_rst_nxt;
      r_cs_n    <= w_cs_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rst_nxt   = r_sid_rst;
    w_cs_nxt    = r_cs_n;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    w_shadow_we = 1'b0;
    case (r_state)
      S_RESET: begin
        // Count sid_clk falls; release sid_rst on the next update strobe.
        if (w_fall && (r_rcnt != RCNT_W'(RST_CYCLES))) begin
          w_rcnt_nxt = r_rcnt + RCNT_W'(1);
        end
        if (w_stb && (r_rcnt == RCNT_W'(RST_CYCLES))) begin
          w_rst_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE, S_WRITE: begin
        if (w_stb) begin
          if (!w_empty) begin
            w_pop = 1'b1;
            if (w_h_valid) begin
              w_cs_nxt    = w_h_sel_n;
              w_rw_nxt    = 1'b0;
              w_addr_nxt  = w_h_addr;
              w_data_nxt  = w_h_data;
              w_shadow_we = 1'b1;
              w_state_nxt = S_WRITE;
            end else begin
              w_cs_nxt    = '1;
              w_rw_nxt    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            // Address and data keep their last value when the bus idles.
            w_cs_nxt    = '1;
            w_rw_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

`ifdef SID_MIRROR_EN
  // Shadow register mirror
  logic [7:0] r_shadow [NUM_SID][32];
  logic [4:0] r_clr_idx;
  logic [7:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx <= '0;
    end else if (r_state == S_RESET) begin
      r_clr_idx <= r_clr_idx + 5'd1;
    end
  end

  // One address (across all chips) is cleared per clk while the reset
  // sequence runs; the sequence is far longer than 32 clk.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SID; i++) begin
      if (r_state == S_RESET) begin
        r_shadow[i][r_clr_idx] <= 8'h00;
      end else if (w_shadow_we && (w_h_bcast || (w_h_chip == CHIP_W'(i)))) begin
        r_shadow[i][w_h_addr] <= w_h_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if ({1'b0, rd_chip} < (CHIP_W + 1)'(NUM_SID)) begin
      r_rd_data <= r_shadow[rd_chip][rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
`else
  logic w_mirror_unused;
  assign w_mirror_unused = ^{rd_chip, rd_addr, w_shadow_we};
  assign rd_data = 8'h00;
`endif

  assign sid_clk    = r_sid_clk;
  assign sid_addr   = r_addr;
  assign sid_data   = r_data;
  assign sid_cs_n   = r_cs_n;
  assign sid_rw     = r_rw;
  assign sid_rst    = r_sid_rst;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_sid_multi_writer.sv
// tb_sid_multi_writer
//   Self-checking bench for sid_multi_writer (NUM_SID=2, FIFO_DEPTH=16,
//   CLK_DIV=16, RST_CYCLES=16). Expected bus writes are queued when a frame
//   is accepted and compared at each sid_clk fall that latches a write.
module tb_sid_multi_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [0:0] wr_chip = '0;
  logic       wr_bcast = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       ovf_clr = 1'b0;
  logic       sid_clk;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic [1:0] sid_cs_n;
  logic       sid_rw;
  logic       sid_rst;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       busy;
  logic [0:0] rd_chip = '0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data;

  sid_multi_writer #(
    .NUM_SID(2), .FIFO_DEPTH(16), .CLK_DIV(16), .RST_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chip(wr_chip),
    .wr_bcast(wr_bcast), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .sid_clk(sid_clk), .sid_addr(sid_addr),
    .sid_data(sid_data), .sid_cs_n(sid_cs_n), .sid_rw(sid_rw),
    .sid_rst(sid_rst), .fifo_level(fifo_level), .overflow(overflow),
    .busy(busy), .rd_chip(rd_chip), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bcast;
    logic       chip;
    logic [4:0] addr;
    logic [7:0] data;
    logic [1:0] exp_cs_n;
  } vec_t;

  typedef struct {
    logic [1:0] cs_n;
    logic [4:0] addr;
    logic [7:0] data;
  } sb_t;

  vec_t tbl [16];
  sb_t  sb [$];
  sb_t  mon_e;
  logic mon_prev = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef SID_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a write is latched by the SID on each sid_clk fall.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else begin
      if (mon_prev && !sid_clk && !sid_rw) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: cs_n=%b addr=%h data=%h, expected no write",
                   sid_cs_n, sid_addr, sid_data);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_cs_n", 32'(sid_cs_n), 32'(mon_e.cs_n));
          chk("wr_addr", 32'(sid_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(sid_data), 32'(mon_e.data));
        end
      end
      mon_prev = sid_clk;
    end
  end

  task automatic check_rst_seq();
    int   falls = 0;
    int   viol = 0;
    int   cyc = 0;
    logic prev;
    prev = sid_clk;
    while (sid_rst !== 1'b1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (prev && !sid_clk) falls++;
      prev = sid_clk;
      if (sid_rst !== 1'b1 && sid_cs_n !== 2'b11) viol++;
    end
    chk("rst_seq_timeout", 32'(cyc < 600), 32'd1);
    chk("rst_seq_falls", 32'(falls), 32'd16);
    chk("rst_seq_cs_idle", 32'(viol), 32'd0);
  endtask

  task automatic wait_idle(input string nm);
    int cyc = 0;
    while (busy !== 1'b0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  // Push one frame at a negedge; returns the number of cycles until the
  // chip select drops, and how long the write stays on the bus.
  task automatic single_write(input logic bc, input logic ch, input logic [4:0] a,
                              input logic [7:0] d, input logic [1:0] cs,
                              output int lat, output int dur);
    sb_t e;
    @(negedge clk);
    wr_valid = 1'b1; wr_bcast = bc; wr_chip = ch; wr_addr = a; wr_data = d;
    e.cs_n = cs; e.addr = a; e.data = d;
    sb.push_back(e);
    @(negedge clk);
    wr_valid = 1'b0;
    lat = 0;
    while (sid_cs_n === 2'b11 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    dur = 0;
    while (sid_cs_n === cs && sid_rw === 1'b0 && dur < 40) begin
      @(negedge clk);
      dur++;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, dur, gaps, cyc;
    sb_t e;

    tbl[0]  = '{1'b0, 1'b0, 5'h08, 8'h11, 2'b10};
    tbl[1]  = '{1'b0, 1'b1, 5'h09, 8'h22, 2'b01};
    tbl[2]  = '{1'b1, 1'b0, 5'h0A, 8'h33, 2'b00};
    tbl[3]  = '{1'b0, 1'b0, 5'h0B, 8'h44, 2'b10};
    tbl[4]  = '{1'b0, 1'b1, 5'h0C, 8'h55, 2'b01};
    tbl[5]  = '{1'b1, 1'b1, 5'h0D, 8'h66, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 5'h0E, 8'h77, 2'b10};
    tbl[7]  = '{1'b0, 1'b0, 5'h0F, 8'h88, 2'b10};
    tbl[8]  = '{1'b0, 1'b1, 5'h10, 8'h99, 2'b01};
    tbl[9]  = '{1'b0, 1'b1, 5'h11, 8'hAA, 2'b01};
    tbl[10] = '{1'b1, 1'b0, 5'h12, 8'hBB, 2'b00};
    tbl[11] = '{1'b0, 1'b0, 5'h13, 8'hCC, 2'b10};
    tbl[12] = '{1'b0, 1'b1, 5'h14, 8'hDD, 2'b01};
    tbl[13] = '{1'b0, 1'b0, 5'h15, 8'hEE, 2'b10};
    tbl[14] = '{1'b1, 1'b1, 5'h16, 8'hFF, 2'b00};
    tbl[15] = '{1'b0, 1'b0, 5'h17, 8'h5A, 2'b10};

    // Reset values while rst_n is held low
    #20;
    chk("rst_sid_clk", 32'(sid_clk), 32'd0);
    chk("rst_cs_n", 32'(sid_cs_n), 32'h3);
    chk("rst_rw", 32'(sid_rw), 32'd1);
    chk("rst_sid_rst", 32'(sid_rst), 32'd0);
    chk("rst_addr", 32'(sid_addr), 32'd0);
    chk("rst_data", 32'(sid_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    #30;
    rst_n = 1'b1;

    // Reset sequence in parallel with a 20-frame burst into a 16-deep FIFO
    fork
      check_rst_seq();
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("burst_wr_ready", 32'(wr_ready), 32'(i < 16));
          wr_valid = 1'b1;
          if (i < 16) begin
            wr_bcast = tbl[i].bcast; wr_chip = tbl[i].chip;
            wr_addr = tbl[i].addr;   wr_data = tbl[i].data;
            e.cs_n = tbl[i].exp_cs_n; e.addr = tbl[i].addr; e.data = tbl[i].data;
            sb.push_back(e);
          end else begin
            wr_bcast = 1'b0; wr_chip = 1'b0;
            wr_addr = 5'h1F; wr_data = 8'(8'hF0 + i);
          end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        chk("full_level", 32'(fifo_level), 32'd16);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_busy", 32'(busy), 32'd1);
        // Drop and clear together: the drop wins
        wr_valid = 1'b1; ovf_clr = 1'b1; wr_addr = 5'h1E;
        @(negedge clk);
        wr_valid = 1'b0; ovf_clr = 1'b0;
        chk("drop_vs_clr", 32'(overflow), 32'd1);
        chk("full_level_hold", 32'(fifo_level), 32'd16);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
      end
    join

    // Drain: back-to-back writes with no idle gap on the bus
    cyc = 0;
    while (sid_cs_n === 2'b11 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_start", 32'(cyc < 64), 32'd1);
    gaps = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (sid_cs_n === 2'b11 || sid_rw !== 1'b0) gaps++;
    end
    chk("drain_gaps", 32'(gaps), 32'd0);
    wait_idle("drain_idle");
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Single write to chip 1
    single_write(1'b0, 1'b1, 5'h18, 8'h0F, 2'b01, lat, dur);
    chk("single_latency_ok", 32'(lat >= 1 && lat <= 17), 32'd1);
    chk("single_duration", 32'(dur), 32'd16);
    chk("single_end_cs_n", 32'(sid_cs_n), 32'h3);
    chk("single_end_rw", 32'(sid_rw), 32'd1);
    chk("single_hold_addr", 32'(sid_addr), 32'h18);
    chk("single_hold_data", 32'(sid_data), 32'h0F);
    wait_idle("single_idle");

    // Broadcast write
    single_write(1'b1, 1'b0, 5'h04, 8'h41, 2'b00, lat, dur);
    chk("bcast_latency_ok", 32'(lat >= 1 && lat <= 17), 32'd1);
    chk("bcast_duration", 32'(dur), 32'd16);
    wait_idle("bcast_idle");
    chk("bcast_sb_empty", 32'(sb.size()), 32'd0);

    // Mirror readback
    @(negedge clk); rd_chip = 1'b0; rd_addr = 5'h04;
    @(negedge clk); chk("mirror_c0_a04", 32'(rd_data), MIRROR ? 32'h41 : 32'h0);
    rd_chip = 1'b1; rd_addr = 5'h04;
    @(negedge clk); chk("mirror_c1_a04", 32'(rd_data), MIRROR ? 32'h41 : 32'h0);
    rd_chip = 1'b1; rd_addr = 5'h18;
    @(negedge clk); chk("mirror_c1_a18", 32'(rd_data), MIRROR ? 32'h0F : 32'h0);
    rd_chip = 1'b0; rd_addr = 5'h18;
    @(negedge clk); chk("mirror_c0_a18", 32'(rd_data), 32'h0);
    rd_chip = 1'b0; rd_addr = 5'h0B;
    @(negedge clk); chk("mirror_c0_a0b", 32'(rd_data), MIRROR ? 32'h44 : 32'h0);

    // Reset in the middle of a write to chip 0 with one frame still queued
    @(negedge clk);
    wr_valid = 1'b1; wr_bcast = 1'b0; wr_chip = 1'b0; wr_addr = 5'h01; wr_data = 8'hA5;
    e.cs_n = 2'b10; e.addr = 5'h01; e.data = 8'hA5; sb.push_back(e);
    @(negedge clk);
    wr_addr = 5'h02; wr_data = 8'h5A;
    e.cs_n = 2'b10; e.addr = 5'h02; e.data = 8'h5A; sb.push_back(e);
    @(negedge clk);
    wr_valid = 1'b0;
    cyc = 0;
    while (sid_cs_n !== 2'b10 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_write_seen", 32'(sid_cs_n), 32'h2);
    chk("midrst_level_pre", 32'(fifo_level), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(sid_cs_n), 32'h3);
    chk("midrst_sid_rst", 32'(sid_rst), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_rw", 32'(sid_rw), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_rst_seq();
    repeat (48) @(negedge clk);
    chk("midrst_no_stale_cs", 32'(sid_cs_n), 32'h3);
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_level_post", 32'(fifo_level), 32'd0);
    @(negedge clk); rd_chip = 1'b0; rd_addr = 5'h04;
    @(negedge clk); chk("mirror_cleared", 32'(rd_data), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
